object_buffer: RTL and testbench
================================

// Module: object_buffer
// PURPOSE
// - Per-frame object FIFO that sits directly upstream of task_dispatcher.
// - The scene loader writes objects in; the head object is broadcast to all
//   UNITS render units.
// - Pops one object per next_object rising edge.
// - Raises read_end once the frame's last-tagged object has been consumed.
//   It holds read_end until the buffer switcher pulses swap.
// PARAMETERS
// - OBJ_WIDTH  64  bits per object record
// - DEPTH      32  FIFO entries; power of two, >= 2
// PORTS
// - clk          in   1          single clock; all logic is on posedge
// - rst          in   1          synchronous, active-high reset
// - wr_valid     in   1          loader offers an object
// - wr_ready     out  1          buffer can accept; equals !full
// - wr_data      in   OBJ_WIDTH  object record
// - wr_last      in   1          this object is the last of its frame
// - next_object  in   1          level from task_dispatcher; all units complete
// - swap         in   1          1-cycle pulse from buffer switcher; frame retired
// - obj_valid    out  1          obj_data holds the current object
// - obj_start    out  1          1-cycle pulse when a new object is presented
// - obj_data     out  OBJ_WIDTH  current head object, broadcast to units
// - read_end     out  1          frame's last object consumed; waiting for swap
// - fill         out  $clog2(DEPTH)+1  number of occupied entries
// BEHAVIOUR
// - Reset values:
//   - All outputs 0; wr_ready=1 after the reset cycle; state=EMPTY.
//   - Pointers and the next_object edge register are 0.
//   - Storage contents are don't-care.
// - Push: occurs when wr_valid & wr_ready.
//   - Stores {wr_last, wr_data}; fill+1 on the next cycle.
//   - Full: wr_ready=0 even when a pop happens in the same cycle. There is no
//     simultaneous push-at-full.
// - Pop trigger: nobj_rise = next_object & ~next_object_q.
//   - A held-high level never pops twice; next_object must drop before the
//     next pop.
// - States:
//   - EMPTY
//     - obj_valid=0.
//     - Goes to PRESENT the cycle after fill becomes nonzero; obj_start=1
//       in that cycle.
//     - No fall-through: a push into an empty buffer is visible 1 cycle later.
//   - PRESENT
//     - obj_valid=1; obj_data = head entry, held stable.
//     - On nobj_rise: pop the head.
//       - Popped entry had last=1: go to DRAINED and set read_end=1 next cycle.
//       - Otherwise, entries remain: stay in PRESENT and pulse obj_start next
//         cycle with the new head.
//       - Otherwise: go to EMPTY.
//   - DRAINED
//     - obj_valid=0 and read_end=1, even if next-frame objects are already
//       buffered; frames never overlap.
//     - Pushes are still accepted.
//     - On swap: clear read_end and go to PRESENT (pulse obj_start) if
//       fill>0, else to EMPTY.
// - next_object and nobj_rise are ignored in EMPTY and DRAINED.
// - swap is ignored outside DRAINED, including the same cycle as the popping
//   of the last object: read_end still rises.
// - Push and pop in the same cycle: fill unchanged; both pointers advance.
//   Pointers wrap modulo DEPTH.
// - wr_last on an object pushed while the previous frame is in DRAINED tags
//   the new frame only.
// - Reset mid-frame: all buffered objects are discarded; reset values apply
//   the next cycle.
// CONFIGURATION
// - OBJECT_BUFFER_STATS_EN
//   - Defined: adds output frame_objs [15:0], the objects popped in the
//     current frame.
//     - +1 per pop, saturating at 16'hFFFF.
//     - Cleared to 0 on rst and on the swap accepted in DRAINED.
//     - Holds its value while read_end=1.
//   - Undefined: the port and counter do not exist; all other behaviour is
//     identical.
// TESTING
// - rst, push A,B,C(last) -> fill=3; obj_valid=1 and obj_start pulse on the
//   cycle after A's push; obj_data=A.
// - Hold next_object=1 for 5 cycles -> exactly one pop; obj_data=B.
//   Toggle low/high twice -> C presented and popped; read_end=1, obj_valid=0.
// - In DRAINED push D,E(last), then pulse swap -> read_end=0; obj_start
//   pulse; obj_data=D; fill=2.
// - Push 32 entries -> wr_ready=0 at fill=32. Pop and push in the same cycle
//   -> push refused. Next cycle wr_ready=1, fill=31.
// - Pop C(last) with swap in the same cycle -> read_end=1 and stays 1;
//   a second swap is needed to clear it.
// - rst asserted with fill=5 in PRESENT -> next cycle fill=0, obj_valid=0,
//   read_end=0, wr_ready=1. With STATS_EN, frame_objs=0.

Source files
------------

// File: rtl/object_buffer.sv
// Per-frame object FIFO feeding task_dispatcher; head object broadcast to units.
// Optional OBJECT_BUFFER_STATS_EN adds the frame_objs pop counter output.
module object_buffer #(
    parameter int OBJ_WIDTH = 64,
    parameter int DEPTH     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [OBJ_WIDTH-1:0]   wr_data,
    input  logic                   wr_last,
    input  logic                   next_object,
    input  logic                   swap,
    output logic                   obj_valid,
    output logic                   obj_start,
    output logic [OBJ_WIDTH-1:0]   obj_data,
    output logic                   read_end,
`ifdef OBJECT_BUFFER_STATS_EN
    output logic [15:0]            frame_objs,
`endif
    output logic [$clog2(DEPTH):0] fill
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY,
        PRESENT,
        DRAINED
    } state_t;

    logic [OBJ_WIDTH:0] mem [DEPTH];
    logic [OBJ_WIDTH:0] head;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        fill_nxt;
    logic               nobj_q;
    logic               push;
    logic               pop;
    state_t             state;

    assign wr_ready = (fill != FULL_CNT);
    assign push     = wr_valid & wr_ready;
    assign pop      = (state == PRESENT) & next_object & ~nobj_q;
    assign head     = mem[rd_ptr];
    assign obj_data = obj_valid ? head[OBJ_WIDTH-1:0] : '0;

    always_comb begin
        fill_nxt = fill;
        if (push && !pop)
            fill_nxt = fill + 1'b1;
        else if (pop && !push)
            fill_nxt = fill - 1'b1;
    end

    // Storage has no reset; contents are only read once counted in fill.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {wr_last, wr_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            nobj_q    <= 1'b0;
            obj_valid <= 1'b0;
            obj_start <= 1'b0;
            read_end  <= 1'b0;
        end else begin
            nobj_q    <= next_object;
            fill      <= fill_nxt;
            obj_start <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case (state)
                EMPTY: begin
                    if (fill != '0) begin
                        state     <= PRESENT;
                        obj_valid <= 1'b1;
                        obj_start <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (pop) begin
                        if (head[OBJ_WIDTH]) begin
                            state     <= DRAINED;
                            obj_valid <= 1'b0;
                            read_end  <= 1'b1;
                        end else if (fill_nxt != '0) begin
                            obj_start <= 1'b1;
                        end else begin
                            state     <= EMPTY;
                            obj_valid <= 1'b0;
                        end
                    end
                end
                DRAINED: begin
                    if (swap) begin
                        read_end <= 1'b0;
                        if (fill != '0) begin
                            state     <= PRESENT;
                            obj_valid <= 1'b1;
                            obj_start <= 1'b1;
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef OBJECT_BUFFER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            frame_objs <= '0;
        else if (state == DRAINED && swap)
            frame_objs <= '0;
        else if (pop && frame_objs != 16'hFFFF)
            frame_objs <= frame_objs + 1'b1;
    end
`endif

endmodule

// File: tb/tb_object_buffer.sv
// Bench for object_buffer: directed scenarios plus randomized traffic
// checked by a scoreboard of pushed objects in presentation order.
module tb_object_buffer;

    localparam int W = 64;
    localparam int D = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_valid;
    logic         wr_ready;
    logic [W-1:0] wr_data;
    logic         wr_last;
    logic         next_object;
    logic         swap;
    logic         obj_valid;
    logic         obj_start;
    logic [W-1:0] obj_data;
    logic         read_end;
    logic [5:0]   fill;
`ifdef OBJECT_BUFFER_STATS_EN
    logic [15:0]  frame_objs;
`endif

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } obj_t;

    obj_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    object_buffer #(.OBJ_WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .next_object (next_object),
        .swap        (swap),
        .obj_valid   (obj_valid),
        .obj_start   (obj_start),
        .obj_data    (obj_data),
        .read_end    (read_end),
`ifdef OBJECT_BUFFER_STATS_EN
        .frame_objs  (frame_objs),
`endif
        .fill        (fill)
    );

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; record an accepted push after the edge commits it.
    task automatic tick();
        bit   acc;
        obj_t p;
        acc = (wr_valid === 1'b1) && (wr_ready === 1'b1);
        p   = {wr_last, wr_data};
        @(posedge clk);
        #1;
        if (rst)
            sb.delete();
        else if (acc)
            sb.push_back(p);
    endtask

    task automatic push_obj(input logic [W-1:0] d, input logic l);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        wr_valid    = 1'b0;
        wr_last     = 1'b0;
        next_object = 1'b0;
        swap        = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pop_rise();
        next_object = 1'b1;
        tick();
        next_object = 1'b0;
        tick();
    endtask

    task automatic pulse_swap();
        swap = 1'b1;
        tick();
        swap = 1'b0;
    endtask

    // Monitor: every presented object must be the oldest unpresented push.
    initial begin
        bit           pre_re;
        bit           cur_last;
        logic [W-1:0] cur;
        int           fcnt;
        obj_t         e;
        pre_re   = 1'b0;
        cur_last = 1'b0;
        cur      = '0;
        fcnt     = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                pre_re = 1'b0;
                fcnt   = 0;
            end else begin
                if (pre_re && !read_end)
                    fcnt = 0;
                if (obj_start) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL start_no_object: got %0h expected none",
                                 obj_data);
                    end else begin
                        e = sb.pop_front();
                        chk("start_data", obj_data, e.data);
                        cur      = e.data;
                        cur_last = e.last;
                        fcnt++;
                    end
                end else if (obj_valid) begin
                    chk("held_data", obj_data, cur);
                end
                chk("fill", W'(fill), W'(sb.size() + int'(obj_valid)));
                chk("wr_ready", W'(wr_ready),
                    W'((sb.size() + int'(obj_valid)) < D));
                if (read_end && !pre_re) begin
                    chk("read_end_last", W'(cur_last), 1);
`ifdef OBJECT_BUFFER_STATS_EN
                    chk("frame_objs", W'(frame_objs), W'(fcnt));
`endif
                end
                if (read_end)
                    chk("drained_invalid", W'(obj_valid), 0);
                pre_re = read_end;
            end
        end
    end

    initial begin
        bit done;
        rst         = 1'b1;
        wr_valid    = 1'b0;
        wr_data     = '0;
        wr_last     = 1'b0;
        next_object = 1'b0;
        swap        = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_fill", W'(fill), 0);
        chk("rst_valid", W'(obj_valid), 0);
        chk("rst_start", W'(obj_start), 0);
        chk("rst_read_end", W'(read_end), 0);
        chk("rst_wr_ready", W'(wr_ready), 1);
        chk("rst_data", obj_data, 0);

        push_obj(64'hA, 1'b0);
        chk("no_fallthrough", W'(obj_valid), 0);
        push_obj(64'hB, 1'b0);
        chk("a_valid", W'(obj_valid), 1);
        chk("a_start", W'(obj_start), 1);
        chk("a_data", obj_data, 64'hA);
        push_obj(64'hC, 1'b1);
        chk("abc_fill", W'(fill), 3);
        chk("a_start_pulse", W'(obj_start), 0);

        next_object = 1'b1;
        repeat (5) tick();
        chk("held_pop_data", obj_data, 64'hB);
        chk("held_pop_fill", W'(fill), 2);
        next_object = 1'b0;
        tick();
        next_object = 1'b1;
        tick();
        chk("c_data", obj_data, 64'hC);
        next_object = 1'b0;
        tick();
        next_object = 1'b1;
        tick();
        next_object = 1'b0;
        chk("c_read_end", W'(read_end), 1);
        chk("c_invalid", W'(obj_valid), 0);
`ifdef OBJECT_BUFFER_STATS_EN
        chk("c_frame_objs", W'(frame_objs), 3);
`endif

        push_obj(64'hD, 1'b0);
        push_obj(64'hE, 1'b1);
        tick();
        chk("de_read_end", W'(read_end), 1);
        chk("de_invalid", W'(obj_valid), 0);
        chk("de_fill", W'(fill), 2);
        pulse_swap();
        chk("swap_read_end", W'(read_end), 0);
        chk("swap_start", W'(obj_start), 1);
        chk("swap_data", obj_data, 64'hD);
        chk("swap_fill", W'(fill), 2);
`ifdef OBJECT_BUFFER_STATS_EN
        chk("swap_frame_objs", W'(frame_objs), 0);
`endif
        pop_rise();
        chk("e_data", obj_data, 64'hE);
        pop_rise();
        chk("e_read_end", W'(read_end), 1);
        pulse_swap();
        chk("empty_after_swap", W'(obj_valid), 0);

        for (int i = 0; i < D; i++)
            push_obj(W'(100 + i), 1'b0);
        chk("full_fill", W'(fill), 32);
        chk("full_ready", W'(wr_ready), 0);
        wr_valid    = 1'b1;
        wr_data     = 64'hDEAD;
        next_object = 1'b1;
        tick();
        wr_valid    = 1'b0;
        next_object = 1'b0;
        chk("full_pop_fill", W'(fill), 31);
        chk("full_pop_ready", W'(wr_ready), 1);
        chk("full_pop_data", obj_data, 101);

        do_reset();
        push_obj(64'h51, 1'b0);
        push_obj(64'h52, 1'b1);
        push_obj(64'h53, 1'b0);
        pop_rise();
        chk("y_data", obj_data, 64'h52);
        next_object = 1'b1;
        swap        = 1'b1;
        tick();
        next_object = 1'b0;
        swap        = 1'b0;
        chk("swap_same_cycle", W'(read_end), 1);
        repeat (3) tick();
        chk("read_end_holds", W'(read_end), 1);
        pulse_swap();
        chk("second_swap", W'(read_end), 0);
        chk("z_start", W'(obj_start), 1);
        chk("z_data", obj_data, 64'h53);

        do_reset();
        for (int i = 0; i < 6; i++)
            push_obj(W'(200 + i), 1'b0);
        tick();
        pop_rise();
        chk("pre_rst_fill", W'(fill), 5);
        chk("pre_rst_valid", W'(obj_valid), 1);
        do_reset();
        chk("mid_rst_fill", W'(fill), 0);
        chk("mid_rst_valid", W'(obj_valid), 0);
        chk("mid_rst_read_end", W'(read_end), 0);
        chk("mid_rst_ready", W'(wr_ready), 1);
`ifdef OBJECT_BUFFER_STATS_EN
        chk("mid_rst_frame_objs", W'(frame_objs), 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            wr_valid    = 1'($urandom_range(0, 1));
            wr_data     = {$urandom, $urandom};
            wr_last     = ($urandom_range(0, 7) == 0);
            next_object = 1'($urandom_range(0, 1));
            swap        = ($urandom_range(0, 4) == 0);
            tick();
        end
        wr_valid    = 1'b0;
        wr_last     = 1'b0;
        swap        = 1'b0;
        done        = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (fill == 0 && !obj_valid && !read_end) begin
                done = 1'b1;
                break;
            end
            next_object = ~next_object;
            swap        = read_end;
            tick();
        end
        next_object = 1'b0;
        swap        = 1'b0;
        chk("drain_bound", W'(done), 1);
        tick();
        @(negedge clk);
        #1;
        chk("scoreboard_empty", W'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
